// File: rtl/dsec_ctrl_seq_if.sv
// DSEC control-sequencer bundle: external handshake, per-stage status and sequencer outputs.
// err_count is present only when DSEC_ERR_COUNT_EN is defined.
interface dsec_ctrl_seq_if #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned ERR_W      = 64
);
  logic                  key_config;
  logic                  in_valid;
  logic                  out_rcvd;
  logic                  err_clr;
  logic [NUM_STAGES-1:0] stage_rdy;
  logic [NUM_STAGES-1:0] stage_err;
  logic                  stall;
  logic                  rdy;
  logic                  out_valid;
  logic                  error;
  logic [ERR_W-1:0]      error_code;
  logic                  busy;
`ifdef DSEC_ERR_COUNT_EN
  logic [15:0]           err_count;

  modport master (
    output key_config, in_valid, out_rcvd, err_clr, stage_rdy, stage_err,
    input  stall, rdy, out_valid, error, error_code, busy, err_count
  );
  modport slave (
    input  key_config, in_valid, out_rcvd, err_clr, stage_rdy, stage_err,
    output stall, rdy, out_valid, error, error_code, busy, err_count
  );
`else
  modport master (
    output key_config, in_valid, out_rcvd, err_clr, stage_rdy, stage_err,
    input  stall, rdy, out_valid, error, error_code, busy
  );
  modport slave (
    input  key_config, in_valid, out_rcvd, err_clr, stage_rdy, stage_err,
    output stall, rdy, out_valid, error, error_code, busy
  );
`endif
endinterface

// File: rtl/dsec_ctrl_seq.sv
// DSEC control sequencer: tracks beats through the stage pipeline, drives global stall/rdy/
// out_valid, enforces the out_rcvd timeout and latches the first error. Optional: DSEC_ERR_COUNT_EN.
module dsec_ctrl_seq #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned PIPE_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned ERR_W      = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  dsec_ctrl_seq_if.slave bus
);

  localparam int unsigned     TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              TmoEn   = (TIMEOUT != 0);
  localparam logic [TmoW-1:0] TmoLast = TmoW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StCfg, StErr} state_e;

  state_e                r_state;
  logic [PIPE_DEPTH-1:0] r_vpipe;
  logic [TmoW-1:0]       r_tmo_cnt;
  logic                  r_error;
  logic [7:0]            r_code;
`ifdef DSEC_ERR_COUNT_EN
  logic [15:0]           r_err_count;
`endif

  logic                  w_out_valid;
  logic                  w_stall;
  logic                  w_rdy;
  logic                  w_accept;
  logic                  w_wait;
  logic                  w_tmo_hit;
  logic                  w_any_err;
  logic [3:0]            w_err_code;
  logic [3:0]            w_err_idx;
  logic [PIPE_DEPTH-1:0] w_vpipe_shift;

  assign w_out_valid = r_vpipe[PIPE_DEPTH-1];
  assign w_wait      = w_out_valid & ~bus.out_rcvd;
  assign w_stall     = (r_state != StRun) | bus.key_config | w_wait | ~(&bus.stage_rdy);
  assign w_rdy       = (r_state == StRun) & ~w_stall;
  assign w_accept    = w_rdy & bus.in_valid;
  assign w_tmo_hit   = TmoEn & w_wait & (r_tmo_cnt == TmoLast);

  always_comb begin
    w_vpipe_shift    = r_vpipe << 1;
    w_vpipe_shift[0] = w_accept;
  end

  // Descending scan leaves the lowest set stage index.
  always_comb begin
    w_err_idx = 4'd0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (bus.stage_err[i]) w_err_idx = 4'(i);
    end
  end

  always_comb begin
    w_err_code = 4'd0;
    if (|bus.stage_err)                       w_err_code = 4'd1;
    else if (w_tmo_hit)                       w_err_code = 4'd2;
    else if (bus.in_valid & bus.key_config)   w_err_code = 4'd3;
    else if (bus.out_rcvd & ~w_out_valid)     w_err_code = 4'd4;
  end

  assign w_any_err = (w_err_code != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_vpipe     <= '0;
      r_tmo_cnt   <= '0;
      r_error     <= 1'b0;
      r_code      <= 8'd0;
`ifdef DSEC_ERR_COUNT_EN
      r_err_count <= 16'd0;
`endif
    end else begin
      if (!w_stall) r_vpipe <= w_vpipe_shift;

      if (w_wait) r_tmo_cnt <= (r_tmo_cnt == '1) ? r_tmo_cnt : r_tmo_cnt + 1'b1;
      else        r_tmo_cnt <= '0;

      case (r_state)
        StIdle: r_state <= StRun;
        StRun, StCfg: begin
          if (w_any_err) begin
            // Stage index field is only nonzero for stage errors (stage_err is 0 otherwise).
            r_state <= StErr;
            r_error <= 1'b1;
            r_code  <= {w_err_idx, w_err_code};
            r_vpipe <= '0;
`ifdef DSEC_ERR_COUNT_EN
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
`endif
          end else begin
            r_state <= bus.key_config ? StCfg : StRun;
          end
        end
        StErr: begin
          // A clear coinciding with a fresh error condition is refused; first code is kept.
          if (bus.err_clr && !w_any_err) begin
            r_state   <= StIdle;
            r_error   <= 1'b0;
            r_tmo_cnt <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.stall      = w_stall;
  assign bus.rdy        = w_rdy;
  assign bus.out_valid  = w_out_valid;
  assign bus.error      = r_error;
  assign bus.error_code = ERR_W'(r_code);
  assign bus.busy       = |r_vpipe;
`ifdef DSEC_ERR_COUNT_EN
  assign bus.err_count  = r_err_count;
`endif

endmodule

// File: tb/tb_dsec_ctrl_seq.sv
// Self-checking bench for dsec_ctrl_seq: directed scenarios plus randomized traffic checked
// against a beat-age queue model of the sequencer.
module tb_dsec_ctrl_seq;
  localparam int unsigned NS  = 2;
  localparam int unsigned PD  = 4;
  localparam int unsigned TMO = 8;
  localparam int unsigned EW  = 64;

  logic clk;
  logic rst_n;

  dsec_ctrl_seq_if #(.NUM_STAGES(NS), .ERR_W(EW)) bus ();

  dsec_ctrl_seq #(
    .NUM_STAGES(NS),
    .PIPE_DEPTH(PD),
    .TIMEOUT   (TMO),
    .ERR_W     (EW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each in-flight beat is kept as its age in shifting edges, oldest first.
  typedef enum int {MIdle, MRun, MCfg, MErr} mstate_e;
  mstate_e    m_state;
  int         m_age[$];
  int         m_wait;
  bit         m_err;
  logic [7:0] m_code;
`ifdef DSEC_ERR_COUNT_EN
  int         m_nerr;
`endif
  bit         e_stall, e_rdy, e_ov, e_busy;
  int         checks;
  int         failures;

  function automatic bit m_ov();
    return (m_age.size() > 0) && (m_age[0] == int'(PD) - 1);
  endfunction

  function automatic void model_eval();
    e_ov    = m_ov();
    e_busy  = (m_age.size() > 0);
    e_stall = (m_state != MRun) || bus.key_config || (e_ov && !bus.out_rcvd) ||
              (bus.stage_rdy != '1);
    e_rdy   = (m_state == MRun) && !e_stall;
  endfunction

  task automatic advance();
    int code;
    int idx;
    @(posedge clk);
    code = 0;
    idx  = 0;
    if (bus.stage_err != '0) begin
      code = 1;
      for (int i = 0; i < int'(NS); i++) begin
        if (bus.stage_err[i]) begin
          idx = i;
          break;
        end
      end
    end else if (TMO != 0 && e_ov && !bus.out_rcvd && m_wait + 1 == int'(TMO)) code = 2;
    else if (bus.in_valid && bus.key_config) code = 3;
    else if (bus.out_rcvd && !e_ov) code = 4;

    if (!e_stall) begin
      foreach (m_age[i]) m_age[i] = m_age[i] + 1;
      if (m_age.size() > 0 && m_age[0] == int'(PD)) void'(m_age.pop_front());
      if (e_rdy && bus.in_valid) m_age.push_back(0);
    end
    m_wait = (e_ov && !bus.out_rcvd) ? m_wait + 1 : 0;

    case (m_state)
      MIdle: m_state = MRun;
      MRun, MCfg: begin
        if (code != 0) begin
          m_state = MErr;
          m_err   = 1'b1;
          m_code  = 8'((idx << 4) | code);
          m_age.delete();
`ifdef DSEC_ERR_COUNT_EN
          if (m_nerr < 65535) m_nerr++;
`endif
        end else begin
          m_state = bus.key_config ? MCfg : MRun;
        end
      end
      MErr: begin
        if (bus.err_clr && code == 0) begin
          m_state = MIdle;
          m_err   = 1'b0;
          m_wait  = 0;
        end
      end
      default: m_state = MIdle;
    endcase
    #1;
  endtask

  task automatic idle_inputs();
    bus.key_config = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_rcvd   = 1'b0;
    bus.err_clr    = 1'b0;
    bus.stage_rdy  = '1;
    bus.stage_err  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n   = 1'b0;
    m_state = MIdle;
    m_age.delete();
    m_wait  = 0;
    m_err   = 1'b0;
    m_code  = 8'd0;
`ifdef DSEC_ERR_COUNT_EN
    m_nerr  = 0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clear_err();
    idle_inputs();
    bus.err_clr = 1'b1;
    @(negedge clk); model_eval(); advance();
    bus.err_clr = 1'b0;
    repeat (2) begin
      @(negedge clk); model_eval(); advance();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.out_valid, bus.error, bus.busy} !== 3'b000 || bus.error_code !== '0) begin
      failures++;
      $display("FAIL reset_regs: got ov=%b err=%b busy=%b code=%0h, want all 0",
               bus.out_valid, bus.error, bus.busy, bus.error_code);
    end
    checks++;
    if (bus.stall !== 1'b1 || bus.rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got stall=%b rdy=%b, want 1/0", bus.stall, bus.rdy);
    end
    do_reset();
    @(negedge clk); model_eval();
    checks++;
    if (bus.rdy !== 1'b0 || bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL idle_cycle: got stall=%b rdy=%b, want 1/0", bus.stall, bus.rdy);
    end
    advance();
    @(negedge clk); model_eval();
    checks++;
    if (bus.rdy !== 1'b1 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL run_entry: got stall=%b rdy=%b, want 0/1", bus.stall, bus.rdy);
    end
    advance();
  endtask

  task automatic test_throughput();
    int acc = 0, nov = 0, first_acc = -1, first_ov = -1, last_ov = -1;
    idle_inputs();
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.in_valid = (acc < 10);
      bus.out_rcvd = m_ov();
      @(negedge clk); model_eval();
      if (bus.rdy && bus.in_valid) begin
        if (acc == 0) first_acc = cyc;
        acc++;
      end
      if (bus.out_valid) begin
        if (nov == 0) first_ov = cyc;
        nov++;
        last_ov = cyc;
      end
      advance();
    end
    checks++;
    if (acc != 10) begin
      failures++; $display("FAIL thr_accepts: got %0d want 10", acc);
    end
    checks++;
    if (first_ov - first_acc != int'(PD)) begin
      failures++; $display("FAIL thr_latency: got %0d want %0d", first_ov - first_acc, PD);
    end
    checks++;
    if (nov != 10 || last_ov - first_ov != 9) begin
      failures++;
      $display("FAIL thr_burst: got %0d beats over %0d cycles, want 10 over 10", nov,
               last_ov - first_ov + 1);
    end
    @(negedge clk); model_eval();
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL thr_drain: got busy=%b ov=%b want 0/0", bus.busy, bus.out_valid);
    end
    advance();
  endtask

  task automatic test_backpressure();
    int acc = 0, cons = 0, hold = 0;
    bit holding;
    idle_inputs();
    for (int cyc = 0; cyc < 40; cyc++) begin
      holding = m_ov() && hold < 4;
      bus.in_valid = holding || acc < 3;
      bus.out_rcvd = holding ? 1'b0 : m_ov();
      @(negedge clk); model_eval();
      if (holding) begin
        checks++;
        if (bus.stall !== 1'b1 || bus.rdy !== 1'b0 || bus.out_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_hold: got stall=%b rdy=%b ov=%b want 1/0/1", bus.stall, bus.rdy,
                   bus.out_valid);
        end
        hold++;
      end
      if (bus.rdy && bus.in_valid) acc++;
      if (bus.out_valid && bus.out_rcvd && !bus.stall) cons++;
      advance();
    end
    checks++;
    if (acc != 3 || cons != 3) begin
      failures++; $display("FAIL bp_count: got acc=%0d cons=%0d want 3/3", acc, cons);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.error !== 1'b0) begin
      failures++; $display("FAIL bp_end: got busy=%b err=%b want 0/0", bus.busy, bus.error);
    end
  endtask

  task automatic test_key_config();
    int acc = 0, kc = 0, nov = 0, first_ov = -1, last_ov = -1;
    idle_inputs();
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.key_config = (acc == 2 && kc < 5);
      bus.in_valid   = (acc < 2);
      bus.out_rcvd   = m_ov();
      @(negedge clk); model_eval();
      if (bus.key_config) begin
        kc++;
        checks++;
        if (bus.stall !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL kc_freeze: got stall=%b ov=%b busy=%b want 1/0/1", bus.stall,
                   bus.out_valid, bus.busy);
        end
      end
      if (bus.rdy && bus.in_valid) acc++;
      if (bus.out_valid) begin
        if (nov == 0) first_ov = cyc;
        nov++;
        last_ov = cyc;
      end
      advance();
    end
    checks++;
    if (nov != 2 || last_ov - first_ov != 1 || bus.error !== 1'b0) begin
      failures++;
      $display("FAIL kc_resume: got %0d beats span %0d err=%b want 2 span 1 err 0", nov,
               last_ov - first_ov, bus.error);
    end
  endtask

  task automatic test_stage_err();
    idle_inputs();
    bus.in_valid = 1'b1;
    @(negedge clk); model_eval(); advance();
    bus.in_valid  = 1'b0;
    bus.stage_err = 2'b10;
    @(negedge clk); model_eval(); advance();
    bus.stage_err = '0;
    @(negedge clk); model_eval();
    checks++;
    if (bus.error !== 1'b1 || bus.error_code !== 64'h11) begin
      failures++;
      $display("FAIL serr_code: got err=%b code=%0h want 1/11", bus.error, bus.error_code);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.stall !== 1'b1 || bus.rdy !== 1'b0)
    begin
      failures++;
      $display("FAIL serr_flush: got ov=%b busy=%b stall=%b rdy=%b want 0/0/1/0", bus.out_valid,
               bus.busy, bus.stall, bus.rdy);
    end
    bus.stage_err = 2'b01;
    advance();
    bus.stage_err = '0;
    @(negedge clk); model_eval();
    checks++;
    if (bus.error_code !== 64'h11) begin
      failures++; $display("FAIL serr_keep_first: got code=%0h want 11", bus.error_code);
    end
    advance();
    bus.err_clr = 1'b1;
    @(negedge clk); model_eval(); advance();
    bus.err_clr = 1'b0;
    @(negedge clk); model_eval();
    checks++;
    if (bus.error !== 1'b0 || bus.error_code !== 64'h11 || bus.rdy !== 1'b0) begin
      failures++;
      $display("FAIL serr_clear: got err=%b code=%0h rdy=%b want 0/11/0", bus.error,
               bus.error_code, bus.rdy);
    end
    advance();
    @(negedge clk); model_eval();
    checks++;
    if (bus.rdy !== 1'b1 || bus.error_code !== 64'h11) begin
      failures++;
      $display("FAIL serr_rerun: got rdy=%b code=%0h want 1/11", bus.rdy, bus.error_code);
    end
    advance();
  endtask

  task automatic test_timeout();
    logic [7:0] want[2] = '{8'h02, 8'h01};
    for (int pass = 0; pass < 2; pass++) begin
      int  wc  = 0;
      bit  got = 1'b0;
      idle_inputs();
      for (int cyc = 0; cyc < 40 && !got; cyc++) begin
        bus.in_valid  = (cyc == 0);
        bus.stage_err = (pass == 1 && m_ov() && m_wait == int'(TMO) - 1) ? NS'(1) : '0;
        @(negedge clk); model_eval();
        if (bus.error) got = 1'b1;
        else if (bus.out_valid) wc++;
        advance();
      end
      checks++;
      if (!got || wc != int'(TMO) || bus.error_code !== EW'(want[pass])) begin
        failures++;
        $display("FAIL timeout_%0d: got err=%b wait=%0d code=%0h want 1/%0d/%0h", pass, got, wc,
                 bus.error_code, TMO, want[pass]);
      end
      clear_err();
    end
  endtask

  task automatic test_random();
    bit kc = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(15) == 0) kc = !kc;
      bus.key_config = kc;
      bus.in_valid   = kc ? ($urandom_range(63) == 0) : ($urandom_range(1) == 1);
      bus.stage_rdy  = ($urandom_range(7) == 0) ? NS'($urandom) : '1;
      bus.out_rcvd   = m_ov() ? ($urandom_range(9) < 7) : ($urandom_range(63) == 0);
      bus.stage_err  = ($urandom_range(127) == 0) ? NS'($urandom_range((1 << NS) - 1, 1)) : '0;
      bus.err_clr    = (m_state == MErr) ? ($urandom_range(3) == 0) : ($urandom_range(63) == 0);
      @(negedge clk); model_eval();
      checks++;
      if (bus.stall !== e_stall || bus.rdy !== e_rdy) begin
        failures++;
        $display("FAIL rnd_stall_rdy cyc=%0d: got %b%b want %b%b", cyc, bus.stall, bus.rdy,
                 e_stall, e_rdy);
      end
      checks++;
      if (bus.out_valid !== e_ov || bus.busy !== e_busy) begin
        failures++;
        $display("FAIL rnd_ov_busy cyc=%0d: got %b%b want %b%b", cyc, bus.out_valid, bus.busy,
                 e_ov, e_busy);
      end
      checks++;
      if (bus.error !== m_err || bus.error_code !== EW'(m_code)) begin
        failures++;
        $display("FAIL rnd_error cyc=%0d: got %b/%0h want %b/%0h", cyc, bus.error,
                 bus.error_code, m_err, m_code);
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    idle_inputs();
    for (int cyc = 0; cyc < 4; cyc++) begin
      bus.in_valid = 1'b1;
      @(negedge clk); model_eval(); advance();
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL arst_pre: got busy=%b want 1", bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.error} !== 3'b000 || bus.error_code !== '0) begin
      failures++;
      $display("FAIL arst_clear: got ov=%b busy=%b err=%b code=%0h want all 0", bus.out_valid,
               bus.busy, bus.error, bus.error_code);
    end
    do_reset();
  endtask

`ifdef DSEC_ERR_COUNT_EN
  task automatic test_err_count();
    do_reset();
    for (int n = 0; n < 2; n++) begin
      idle_inputs();
      @(negedge clk); model_eval(); advance();
      bus.stage_err = NS'(1);
      @(negedge clk); model_eval(); advance();
      bus.stage_err = '0;
      clear_err();
    end
    @(negedge clk); model_eval();
    checks++;
    if (bus.err_count !== 16'd2 || bus.err_count !== 16'(m_nerr)) begin
      failures++; $display("FAIL err_count: got %0d want 2", bus.err_count);
    end
    advance();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_throughput();
    test_backpressure();
    test_key_config();
    test_stage_err();
    test_timeout();
    test_random();
    test_async_reset();
`ifdef DSEC_ERR_COUNT_EN
    test_err_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
